// File: rtl/float64_mul_iter.sv
// Iterative binary64 multiplier with ap_* block handshake.
// Shift-add significand product (one bit per cycle), RNE rounding, subnormal in/out support.
module float64_mul_iter #(
  parameter logic [63:0] DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ap_return
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_NORM, S_MUL, S_PACK, S_DONE} state_t;

  state_t             r_state;
  logic [63:0]        r_a, r_b;
  logic [52:0]        r_ma, r_mb;
  logic signed [12:0] r_ea, r_eb;
  logic               r_sign;
  logic [105:0]       r_acc;
  logic [5:0]         r_cnt;

  logic w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_sub_a, w_sub_b;
  logic w_sign, w_special;
  logic [63:0] w_special_res;

  assign w_nan_a  = (&r_a[62:52]) & (|r_a[51:0]);
  assign w_nan_b  = (&r_b[62:52]) & (|r_b[51:0]);
  assign w_inf_a  = (&r_a[62:52]) & ~(|r_a[51:0]);
  assign w_inf_b  = (&r_b[62:52]) & ~(|r_b[51:0]);
  assign w_zero_a = ~(|r_a[62:0]);
  assign w_zero_b = ~(|r_b[62:0]);
  assign w_sub_a  = ~(|r_a[62:52]) & (|r_a[51:0]);
  assign w_sub_b  = ~(|r_b[62:52]) & (|r_b[51:0]);
  assign w_sign   = r_a[63] ^ r_b[63];
  assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;

  always_comb begin
    w_special_res = {w_sign, 63'd0};
    if (w_nan_a)
      w_special_res = {r_a[63:52], 1'b1, r_a[50:0]};
    else if (w_nan_b)
      w_special_res = {r_b[63:52], 1'b1, r_b[50:0]};
    else if ((w_inf_a & w_zero_b) | (w_zero_a & w_inf_b))
      w_special_res = DEFAULT_NAN;
    else if (w_inf_a | w_inf_b)
      w_special_res = {w_sign, 11'h7FF, 52'd0};
  end

  // Sequential multiplier step: add into the upper half, then shift the whole accumulator right.
  logic [53:0] w_sum;
  assign w_sum = {1'b0, r_acc[105:53]} + (r_mb[0] ? {1'b0, r_ma} : 54'd0);

  logic signed [12:0] w_ze, w_one_minus, w_ef;
  logic [105:0]       w_pn, w_shifted;
  logic [6:0]         w_sh;
  logic [52:0]        w_mant;
  logic               w_g, w_s, w_inc;
  logic [53:0]        w_mr;
  logic [63:0]        w_pack_res;

  always_comb begin
    w_pn        = r_acc[105] ? r_acc : {r_acc[104:0], 1'b0};
    w_ze        = r_ea + r_eb - 13'sd1023 + $signed({12'd0, r_acc[105]});
    w_one_minus = 13'sd1 - w_ze;
    if (w_ze > 13'sd0)
      w_sh = 7'd0;
    else if (w_one_minus > 13'sd107)
      w_sh = 7'd107;
    else
      w_sh = w_one_minus[6:0];
    // Bits lost to the denormalising shift fold into sticky.
    w_shifted = w_pn >> w_sh;
    w_s       = (|w_shifted[51:0]) | ((w_shifted << w_sh) != w_pn);
    w_mant    = w_shifted[105:53];
    w_g       = w_shifted[52];
    w_inc     = w_g & (w_s | w_mant[0]);
    w_mr      = {1'b0, w_mant} + {53'd0, w_inc};
    w_ef      = w_ze + $signed({12'd0, w_mr[53]});
    if (w_ze <= 13'sd0)
      w_pack_res = {r_sign, 10'd0, w_mr[52], w_mr[51:0]};
    else if (w_ef >= 13'sd2047)
      w_pack_res = {r_sign, 11'h7FF, 52'd0};
    else
      w_pack_res = {r_sign, w_ef[10:0], w_mr[51:0]};
  end

  assign ap_idle  = (r_state == S_IDLE) && !ap_start;
  assign ap_ready = ap_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state   <= S_IDLE;
      ap_done   <= 1'b0;
      ap_return <= 64'd0;
    end else begin
      ap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sign <= w_sign;
          r_ma   <= {(|r_a[62:52]), r_a[51:0]};
          r_mb   <= {(|r_b[62:52]), r_b[51:0]};
          r_ea   <= w_sub_a ? 13'sd1 : $signed({2'd0, r_a[62:52]});
          r_eb   <= w_sub_b ? 13'sd1 : $signed({2'd0, r_b[62:52]});
          r_acc  <= 106'd0;
          r_cnt  <= 6'd0;
          if (w_special) begin
            ap_return <= w_special_res;
            ap_done   <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_sub_a | w_sub_b) begin
            r_state <= S_NORM;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_NORM: begin
          // A first, then B; leave on the cycle that sets the last hidden bit.
          if (!r_ma[52]) begin
            r_ma <= {r_ma[51:0], 1'b0};
            r_ea <= r_ea - 13'sd1;
            if (r_ma[51] && r_mb[52]) r_state <= S_MUL;
          end else begin
            r_mb <= {r_mb[51:0], 1'b0};
            r_eb <= r_eb - 13'sd1;
            if (r_mb[51]) r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= {w_sum, r_acc[52:1]};
          r_mb  <= {1'b0, r_mb[52:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd52) r_state <= S_PACK;
        end
        S_PACK: begin
          ap_return <= w_pack_res;
          ap_done   <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
